carry_skip_seq_arbiter: RTL and testbench

Shares one 4-bit carry-skip adder slice between two requesters and sequences it nibble-serially to perform WIDTH-bit additions. The block arbitrates round-robin, latches the winner's operands, and drives the external adder one nibble per cycle, chaining the carry through a register. It returns the full sum, carry-out and requester ID over a valid/ready result port. It sits between the operand sources and the single `n_carry_skip_adder` instance.

---
 rtl/carry_skip_seq_arbiter.sv | 129 ++++++++++++
 tb/tb_carry_skip_seq_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_skip_seq_arbiter.sv
// Round-robin front end that time-shares one external 4-bit adder slice between two
// requesters, performing a WIDTH-bit add one nibble per cycle with a registered carry.
module carry_skip_seq_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_c_in,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_c_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_c_out,
  output logic             res_id,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c_in,
  input  logic [3:0]       add_sum,
  input  logic             add_c_out
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] nib_cnt_reg;
  logic             last_grant_reg;
  logic             id_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       sum_nib_reg [NIB];

  logic [3:0]       a_nib [NIB];
  logic [3:0]       b_nib [NIB];
  logic [WIDTH-1:0] sum_flat;

  logic is_idle;
  logic is_add;
  logic is_done;
  logic grant_id;
  logic accept;

  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*4 +: 4];
      assign b_nib[gi] = b_reg[gi*4 +: 4];
      assign sum_flat[gi*4 +: 4] = sum_nib_reg[gi];
    end
  endgenerate

  assign is_idle = (state_reg == ST_IDLE);
  assign is_add  = (state_reg == ST_ADD);
  assign is_done = (state_reg == ST_DONE);

  // Under contention the requester that did not win last time goes first.
  assign grant_id   = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
  assign req0_ready = rst_n && is_idle && req0_valid && !grant_id;
  assign req1_ready = rst_n && is_idle && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;

  assign add_a    = is_add ? a_nib[nib_cnt_reg] : 4'd0;
  assign add_b    = is_add ? b_nib[nib_cnt_reg] : 4'd0;
  assign add_c_in = is_add & carry_reg;

  assign res_valid = is_done;
  assign res_sum   = is_done ? sum_flat : '0;
  assign res_c_out = is_done & carry_reg;
  assign res_id    = is_done & id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      nib_cnt_reg    <= '0;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      carry_reg      <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      for (int i = 0; i < NIB; i++) begin
        sum_nib_reg[i] <= 4'd0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            a_reg          <= grant_id ? req1_a : req0_a;
            b_reg          <= grant_id ? req1_b : req0_b;
            carry_reg      <= grant_id ? req1_c_in : req0_c_in;
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            nib_cnt_reg    <= '0;
            state_reg      <= ST_ADD;
          end
        end
        ST_ADD: begin
          // The carry register doubles as the final carry-out once the last nibble lands.
          sum_nib_reg[nib_cnt_reg] <= add_sum;
          carry_reg                <= add_c_out;
          if (nib_cnt_reg == LAST_NIB) begin
            state_reg <= ST_DONE;
          end else begin
            nib_cnt_reg <= nib_cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_skip_seq_arbiter.sv
// Self-checking bench for carry_skip_seq_arbiter: behavioural adder slice, reference
// adder model and a result scoreboard, one task per scenario.
module tb_carry_skip_seq_arbiter;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_c_in;
  logic         req1_valid, req1_ready, req1_c_in;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_c_out, res_id;
  logic [W-1:0] res_sum;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_c_in, add_c_out;

  int   checks = 0;
  int   passed = 0;
  logic exp_last;
  exp_t sb[$];

  always #5 clk = ~clk;

  // The shared adder slice is purely combinational.
  assign {add_c_out, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_c_in);

  carry_skip_seq_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_c_in(req0_c_in),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_c_in(req1_c_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_c_out(res_c_out),
    .res_id(res_id),
    .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in), .add_sum(add_sum), .add_c_out(add_c_out)
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic exp_t mk_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic id);
    exp_t x;
    logic [W:0] r;
    r      = ref_add(a, b, c);
    x.sum  = r[W-1:0];
    x.cout = r[W];
    x.id   = id;
    return x;
  endfunction

  // Carry entering nibble k of a+b+c.
  function automatic logic exp_carry(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input int k);
    logic [W-1:0] mask;
    logic [W:0]   lo;
    if (k == 0) return c;
    mask = (W'(1) << (4 * k)) - W'(1);
    lo   = {1'b0, a & mask} + {1'b0, b & mask} + {{W{1'b0}}, c};
    return lo[4 * k];
  endfunction

  function automatic exp_t next_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic id, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic c);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_c_in = c;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_c_in = c;
    end
  endtask

  // Negedges counted from the accept edge until res_valid is seen (bounded).
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 20);
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output int lat);
    int   n;
    logic rdy;
    drive_req(id, 1'b1, a, b, c);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rdy = id ? req1_ready : req0_ready;
    end while (!rdy && n < 20);
    if (!rdy) begin
      drive_req(id, 1'b0, a, b, c);
      lat = -1;
      return;
    end
    sb.push_back(mk_exp(a, b, c, id));
    exp_last = id;
    cyc();
    drive_req(id, 1'b0, a, b, c);
    wait_result(lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; res_ready = 1'b1;
    drive_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    drive_req(1, 1'b1, 16'h3333, 16'h4444, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
    else passed++;
    checks++;
    if ({res_valid, res_c_out, res_id, res_sum, add_a, add_b, add_c_in} !== '0)
      $display("FAIL reset_outputs: valid=%b cout=%b id=%b sum=%h add_a=%h add_b=%h cin=%b, want all 0",
               res_valid, res_c_out, res_id, res_sum, add_a, add_b, add_c_in);
    else passed++;
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
    exp_last = 1'b1;
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [W-1:0] a, b;
    logic         c;
    int           n;
    exp_t         e;
    a = 16'hFFFF; b = 16'h0001; c = 1'b0; res_ready = 1'b1;
    drive_req(0, 1'b1, a, b, c);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL single_grant: ready1,ready0=%b, want 01", {req1_ready, req0_ready});
    else passed++;
    sb.push_back(mk_exp(a, b, c, 1'b0));
    exp_last = 1'b0;
    cyc();
    drive_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= NIB && !res_valid) begin
        checks++;
        if ({add_a, add_b, add_c_in} !== {a[(n-1)*4 +: 4], b[(n-1)*4 +: 4], exp_carry(a, b, c, n-1)})
          $display("FAIL single_nibble%0d: a=%h b=%h cin=%b, want a=%h b=%h cin=%b", n-1, add_a, add_b,
                   add_c_in, a[(n-1)*4 +: 4], b[(n-1)*4 +: 4], exp_carry(a, b, c, n-1));
        else passed++;
      end
    end while (!res_valid && n < 20);
    checks++;
    if (n !== NIB + 1)
      $display("FAIL single_latency: res_valid after %0d edges, want %0d", n - 1, NIB);
    else passed++;
    checks++;
    if ({res_c_out, res_sum, res_id} !== {1'b1, 16'h0000, 1'b0})
      $display("FAIL single_result: cout=%b sum=%h id=%b, want cout=1 sum=0000 id=0",
               res_c_out, res_sum, res_id);
    else passed++;
    e = next_exp();
    checks++;
    if ({res_valid, res_c_out, res_sum, res_id} !== {1'b1, e.cout, e.sum, e.id})
      $display("FAIL single_sb: valid=%b cout=%b sum=%h id=%b, want 1 %b %h %b",
               res_valid, res_c_out, res_sum, res_id, e.cout, e.sum, e.id);
    else passed++;
    $display("test_single a=%h b=%h c=%b -> sum=%h cout=%b id=%b", a, b, c, res_sum, res_c_out, res_id);
    cyc();
  endtask

  task automatic test_carry_in();
    int   lat;
    exp_t e;
    res_ready = 1'b1;
    run_op(1'b1, 16'h1234, 16'h8765, 1'b1, lat);
    checks++;
    if (lat !== NIB + 1) $display("FAIL carry_in_latency: got %0d, want %0d", lat, NIB + 1);
    else passed++;
    checks++;
    if ({res_valid, res_c_out, res_sum, res_id} !== {1'b1, 1'b0, 16'h999A, 1'b1})
      $display("FAIL carry_in_result: valid=%b cout=%b sum=%h id=%b, want 1 0 999a 1",
               res_valid, res_c_out, res_sum, res_id);
    else passed++;
    e = next_exp();
    checks++;
    if ({res_valid, res_c_out, res_sum, res_id} !== {1'b1, e.cout, e.sum, e.id})
      $display("FAIL carry_in_sb: cout=%b sum=%h id=%b, want %b %h %b",
               res_c_out, res_sum, res_id, e.cout, e.sum, e.id);
    else passed++;
    $display("test_carry_in 1234+8765+1 -> sum=%h cout=%b id=%b", res_sum, res_c_out, res_id);
    cyc();
  endtask

  task automatic test_round_robin();
    int   cyc_cnt, last_g, n;
    logic exp_g;
    exp_t e;
    res_ready = 1'b1;
    cyc_cnt = 0; last_g = 0;
    drive_req(0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
    drive_req(1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        cyc_cnt++;
        n++;
        if (res_valid) begin
          e = next_exp();
          checks++;
          if ({res_c_out, res_sum, res_id} !== {e.cout, e.sum, e.id})
            $display("FAIL rr_result: cout=%b sum=%h id=%b, want %b %h %b",
                     res_c_out, res_sum, res_id, e.cout, e.sum, e.id);
          else passed++;
        end
        checks++;
        if (req0_ready && req1_ready) $display("FAIL rr_exclusive: both ready high, want at most one");
        else passed++;
        if (req0_ready || req1_ready) break;
      end
      exp_g = ~exp_last;
      checks++;
      if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01))
        $display("FAIL rr_grant%0d: ready1,ready0=%b, want grant to req%0d", t,
                 {req1_ready, req0_ready}, exp_g);
      else passed++;
      if (t > 0) begin
        checks++;
        if (cyc_cnt - last_g !== NIB + 2)
          $display("FAIL rr_throughput: %0d cycles between grants, want %0d", cyc_cnt - last_g, NIB + 2);
        else passed++;
      end
      last_g = cyc_cnt;
      if (exp_g) sb.push_back(mk_exp(req1_a, req1_b, req1_c_in, 1'b1));
      else       sb.push_back(mk_exp(req0_a, req0_b, req0_c_in, 1'b0));
      exp_last = exp_g;
      $display("test_round_robin grant %0d -> req%0d", t, exp_g);
      cyc();
      // New operands right after the accept must not disturb the in-flight add.
      drive_req(0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      drive_req(1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(n);
    e = next_exp();
    checks++;
    if ({res_valid, res_c_out, res_sum, res_id} !== {1'b1, e.cout, e.sum, e.id})
      $display("FAIL rr_last_result: valid=%b cout=%b sum=%h id=%b, want 1 %b %h %b",
               res_valid, res_c_out, res_sum, res_id, e.cout, e.sum, e.id);
    else passed++;
    cyc();
  endtask

  task automatic test_backpressure();
    int         lat;
    logic [W:0] r;
    exp_t       e;
    res_ready = 1'b0;
    r = ref_add(16'hC0DE, 16'h7F31, 1'b1);
    run_op(1'b0, 16'hC0DE, 16'h7F31, 1'b1, lat);
    checks++;
    if (lat !== NIB + 1) $display("FAIL bp_latency: got %0d, want %0d", lat, NIB + 1);
    else passed++;
    drive_req(1, 1'b1, 16'h0F0F, 16'hF0F1, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({res_valid, res_c_out, res_sum, res_id, req1_ready} !== {1'b1, r[W], r[W-1:0], 1'b0, 1'b0})
        $display("FAIL bp_hold%0d: valid=%b cout=%b sum=%h id=%b ready1=%b, want 1 %b %h 0 0", i,
                 res_valid, res_c_out, res_sum, res_id, req1_ready, r[W], r[W-1:0]);
      else passed++;
    end
    cyc();
    res_ready = 1'b1;
    @(negedge clk);
    e = next_exp();
    checks++;
    if ({res_valid, res_c_out, res_sum, res_id, req1_ready} !== {1'b1, e.cout, e.sum, e.id, 1'b0})
      $display("FAIL bp_release: valid=%b cout=%b sum=%h id=%b ready1=%b, want 1 %b %h %b 0",
               res_valid, res_c_out, res_sum, res_id, req1_ready, e.cout, e.sum, e.id);
    else passed++;
    @(negedge clk);
    checks++;
    if ({res_valid, req1_ready} !== 2'b01)
      $display("FAIL bp_next_grant: valid=%b ready1=%b, want 0 1", res_valid, req1_ready);
    else passed++;
    sb.push_back(mk_exp(16'h0F0F, 16'hF0F1, 1'b0, 1'b1));
    exp_last = 1'b1;
    cyc();
    req1_valid = 1'b0;
    wait_result(lat);
    e = next_exp();
    checks++;
    if ({res_valid, res_c_out, res_sum, res_id} !== {1'b1, e.cout, e.sum, e.id} || lat !== NIB + 1)
      $display("FAIL bp_second: valid=%b cout=%b sum=%h id=%b lat=%0d, want 1 %b %h %b lat=%0d",
               res_valid, res_c_out, res_sum, res_id, lat, e.cout, e.sum, e.id, NIB + 1);
    else passed++;
    $display("test_backpressure second result sum=%h cout=%b id=%b", res_sum, res_c_out, res_id);
    cyc();
  endtask

  task automatic test_reset_mid();
    int   n, lat;
    exp_t e;
    res_ready = 1'b1;
    drive_req(0, 1'b1, 16'hABCD, 16'h1111, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 20);
    checks++;
    if (req0_ready !== 1'b1) $display("FAIL rmid_grant: ready0=%b, want 1", req0_ready);
    else passed++;
    cyc();
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (add_a !== 4'hB) $display("FAIL rmid_nibble2: add_a=%h, want b", add_a);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, add_a, add_b, add_c_in, req0_ready, req1_ready} !== '0)
      $display("FAIL rmid_abort: valid=%b add_a=%h add_b=%h cin=%b ready=%b%b, want all 0",
               res_valid, add_a, add_b, add_c_in, req0_ready, req1_ready);
    else passed++;
    cyc();
    cyc();
    rst_n = 1'b1;
    exp_last = 1'b1;
    @(negedge clk);
    checks++;
    if ({res_valid, add_a, add_c_in} !== '0)
      $display("FAIL rmid_idle: valid=%b add_a=%h cin=%b, want all 0", res_valid, add_a, add_c_in);
    else passed++;
    cyc();
    run_op(1'b0, 16'h7FFF, 16'h8001, 1'b0, lat);
    e = next_exp();
    checks++;
    if ({res_valid, res_c_out, res_sum, res_id} !== {1'b1, e.cout, e.sum, e.id} || lat !== NIB + 1)
      $display("FAIL rmid_recover: valid=%b cout=%b sum=%h id=%b lat=%0d, want 1 %b %h %b lat=%0d",
               res_valid, res_c_out, res_sum, res_id, lat, e.cout, e.sum, e.id, NIB + 1);
    else passed++;
    $display("test_reset_mid recovered sum=%h cout=%b", res_sum, res_c_out);
    cyc();
  endtask

  task automatic test_gating();
    res_ready = 1'b1;
    drive_req(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) $display("FAIL gate_offer: ready0=%b, want 1", req0_ready);
    else passed++;
    req0_valid = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0) $display("FAIL gate_drop: ready0=%b, want 0", req0_ready);
    else passed++;
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, add_a, add_b, add_c_in} !== '0)
        $display("FAIL gate_idle%0d: valid=%b add_a=%h add_b=%h cin=%b, want all 0", i,
                 res_valid, add_a, add_b, add_c_in);
      else passed++;
    end
    $display("test_gating no transaction started");
    cyc();
  endtask

  task automatic test_random();
    int           lat;
    logic         id;
    logic [W-1:0] a, b;
    logic         c;
    exp_t         e;
    res_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      id = 1'($urandom); a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      run_op(id, a, b, c, lat);
      e = next_exp();
      checks++;
      if ({res_valid, res_c_out, res_sum, res_id} !== {1'b1, e.cout, e.sum, e.id} || lat !== NIB + 1)
        $display("FAIL random%0d: valid=%b cout=%b sum=%h id=%b lat=%0d, want 1 %b %h %b lat=%0d", t,
                 res_valid, res_c_out, res_sum, res_id, lat, e.cout, e.sum, e.id, NIB + 1);
      else passed++;
      $display("test_random req%0d %h+%h+%b -> sum=%h cout=%b", id, a, b, c, res_sum, res_c_out);
      cyc();
    end
  endtask

  task automatic test_drain();
    checks++;
    if (sb.size() !== 0) $display("FAIL drain: %0d results outstanding, want 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry_in();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_gating();
    test_random();
    test_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", passed, checks);
    $fatal(1);
  end

endmodule
